// File: rtl/crp_pkg.sv
// Shared types and helpers for the CRP core memory port.
package crp_pkg;

  localparam int unsigned CRP_BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } crpState_e;

  // Effective transaction length: a zero request means one byte, oversize requests saturate.
  function automatic int unsigned crpClampLen(input int unsigned len, input int unsigned maxLen);
    if (len == 0) return 1;
    if (len > maxLen) return maxLen;
    return len;
  endfunction

endpackage

// File: rtl/crp_mem_watchdog.sv
// Per-byte wait-state counter for the CRP memory port.
// Built only when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module crp_mem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic atLimit_c
);

  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] waitCnt;

  // High in the cycle that would be the last tolerated wait cycle.
  assign atLimit_c = run && (waitCnt == LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCnt <= '0;
    end else if (clear) begin
      waitCnt <= '0;
    end else if (run && !atLimit_c) begin
      waitCnt <= waitCnt + CNT_WIDTH'(1);
    end
  end

endmodule
`endif

// File: rtl/crp_mem_port.sv
// Handshaked memory port: serialises a 1..BYTES request onto the byte-wide bus.
// Optional per-byte wait-state timeout enabled by defining MEM_TIMEOUT_EN.
module crp_mem_port
  import crp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 15,
  parameter int unsigned DATA_WIDTH     = CRP_BYTE_WIDTH,
  parameter int unsigned BYTES          = 2,
  parameter int unsigned LEN_WIDTH      = $clog2(BYTES + 1),
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        coreReqValid,
  output logic                        coreReqReady,
  input  logic [ADDR_WIDTH-1:0]       coreAddr,
  input  logic                        coreWrite,
  input  logic [LEN_WIDTH-1:0]        coreLen,
  input  logic [BYTES*DATA_WIDTH-1:0] coreWData,
  output logic                        coreRespValid,
  output logic [BYTES*DATA_WIDTH-1:0] coreRData,
  output logic                        coreRespErr,
  output logic [ADDR_WIDTH-1:0]       memReqBus,
  output logic                        memReqValid,
  output logic                        memWriteReq,
  output logic [DATA_WIDTH-1:0]       memWriteBus,
  input  logic [DATA_WIDTH-1:0]       memReadBus,
  input  logic                        memAck
);

  localparam int unsigned WORD_WIDTH = BYTES * DATA_WIDTH;

  crpState_e             state, stateD;
  logic [LEN_WIDTH-1:0]  idx, idxD;
  logic [LEN_WIDTH-1:0]  lenQ, lenD;
  logic [ADDR_WIDTH-1:0] addrQ, addrD;
  logic                  writeQ, writeD;
  logic [WORD_WIDTH-1:0] wdataQ, wdataD;
  logic [WORD_WIDTH-1:0] rdataD;
  logic                  readyD, memValidD, memWriteD, respValidD, errD;
  logic [ADDR_WIDTH-1:0] memBusD;
  logic [DATA_WIDTH-1:0] memWBusD;
  logic                  wdClear_c;
  logic                  timeoutHit_c;

`ifdef MEM_TIMEOUT_EN
  logic atLimit_c;

  crp_mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uWatchdog (
    .clk      (clk),
    .reset    (reset),
    .run      (state == ACCESS),
    .clear    (wdClear_c),
    .atLimit_c(atLimit_c)
  );

  assign timeoutHit_c = atLimit_c;
`else
  logic unusedTimeout_c;

  assign unusedTimeout_c = (TIMEOUT_CYCLES != 0);
  assign timeoutHit_c    = 1'b0;
`endif

  // Next-state and next-output logic; bus outputs are decoded from the next state.
  always_comb begin
    stateD    = state;
    idxD      = idx;
    lenD      = lenQ;
    addrD     = addrQ;
    writeD    = writeQ;
    wdataD    = wdataQ;
    rdataD    = coreRData;
    errD      = 1'b0;
    wdClear_c = 1'b0;

    case (state)
      IDLE: begin
        if (coreReqValid) begin
          addrD     = coreAddr;
          writeD    = coreWrite;
          lenD      = LEN_WIDTH'(crpClampLen(32'(coreLen), BYTES));
          wdataD    = coreWData;
          rdataD    = '0;
          idxD      = '0;
          wdClear_c = 1'b1;
          stateD    = ACCESS;
        end
      end
      ACCESS: begin
        // An acknowledge always wins over a timeout in the same cycle.
        if (memAck) begin
          wdClear_c = 1'b1;
          if (!writeQ) begin
            rdataD[int'(idx) * DATA_WIDTH +: DATA_WIDTH] = memReadBus;
          end
          if (idx == lenQ - LEN_WIDTH'(1)) begin
            stateD = RESP;
          end else begin
            idxD = idx + LEN_WIDTH'(1);
          end
        end else if (timeoutHit_c) begin
          errD   = 1'b1;
          stateD = RESP;
        end
      end
      RESP: begin
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase

    readyD     = (stateD == IDLE);
    memValidD  = (stateD == ACCESS);
    memWriteD  = (stateD == ACCESS) && writeD;
    respValidD = (stateD == RESP);
    memBusD    = (stateD == ACCESS) ? (addrD + ADDR_WIDTH'(idxD)) : '0;
    memWBusD   = ((stateD == ACCESS) && writeD) ?
                 wdataD[int'(idxD) * DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      lenQ          <= '0;
      addrQ         <= '0;
      writeQ        <= 1'b0;
      wdataQ        <= '0;
      coreRData     <= '0;
      coreReqReady  <= 1'b1;
      coreRespValid <= 1'b0;
      coreRespErr   <= 1'b0;
      memReqValid   <= 1'b0;
      memWriteReq   <= 1'b0;
      memReqBus     <= '0;
      memWriteBus   <= '0;
    end else begin
      state         <= stateD;
      idx           <= idxD;
      lenQ          <= lenD;
      addrQ         <= addrD;
      writeQ        <= writeD;
      wdataQ        <= wdataD;
      coreRData     <= rdataD;
      coreReqReady  <= readyD;
      coreRespValid <= respValidD;
      coreRespErr   <= errD;
      memReqValid   <= memValidD;
      memWriteReq   <= memWriteD;
      memReqBus     <= memBusD;
      memWriteBus   <= memWBusD;
    end
  end

endmodule
